// File: rtl/decoder_pkg.sv
// Shared constants, FSM state type and priority helper for the
// decoder_24 / encoder_42 pair.
package decoder_pkg;

    localparam int N_LINES = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } enc_state_t;

    // Ascending scan so the highest set bit wins.
    function automatic logic [IDX_W-1:0] prio_idx(input logic [N_LINES-1:0] v);
        prio_idx = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (v[i]) prio_idx = i[IDX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/edge_capture.sv
// Rising-edge detector for one request line.
module edge_capture
    import decoder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= 1'b0;
        else        y_q <= d;
    end

    assign rise = d & ~y_q;

endmodule

// File: rtl/encoder_42.sv
// Sequential 4-to-2 priority encoder with pending-request latching
// and a valid/ack handshake on the presented code.
module encoder_42
    import decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       y0,
    input  logic       y1,
    input  logic       y2,
    input  logic       y3,
    input  logic       ack,
    output logic       a,
    output logic       b,
    output logic       valid,
    output logic [3:0] pend,
    output logic       ovf
);

    logic [N_LINES-1:0] y_vec;
    logic [N_LINES-1:0] rise;
    logic [N_LINES-1:0] clr;
    logic [N_LINES-1:0] pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    enc_state_t         state_q, state_d;

    assign y_vec = {y3, y2, y1, y0};

    for (genvar i = 0; i < N_LINES; i++) begin : g_edge
        edge_capture u_edge (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (y_vec[i]),
            .rise (rise[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        clr     = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Registered pend only: a same-cycle edge waits a cycle.
                if (pend_q != '0) begin
                    idx_d   = prio_idx(pend_q);
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ack) begin
                    clr[idx_q] = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
        endcase
        // A set in the clearing cycle wins and is not an overflow.
        pend_d = (pend_q & ~clr) | rise;
        ovf_d  = ovf_q | (|(rise & pend_q & ~clr));
    end

    assign a     = idx_q[1];
    assign b     = idx_q[0];
    assign valid = valid_q;
    assign pend  = pend_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_encoder_42.sv
// Directed + short random bench for encoder_42 with a request-level
// reference model and hand-computed literal checkpoints.
module tb_encoder_42;

    logic       clk;
    logic       rst_n;
    logic [3:0] y;
    logic       ack;
    logic       a, b, valid, ovf;
    logic [3:0] pend;

    int checks = 0;
    int errors = 0;

    encoder_42 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .y0   (y[0]),
        .y1   (y[1]),
        .y2   (y[2]),
        .y3   (y[3]),
        .ack  (ack),
        .a    (a),
        .b    (b),
        .valid(valid),
        .pend (pend),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: request lines seen last cycle, pending set,
    // overflow, and whether a code is currently offered.
    logic [3:0] m_prev, m_pend, m_pend_n, m_rise, m_clr;
    logic       m_ovf, m_present;
    int         m_code, m_top;

    always_comb begin
        m_rise = y & ~m_prev;
        m_clr  = 4'b0000;
        if (m_present && ack) m_clr = 4'b0001 << m_code;
        m_pend_n = (m_pend & ~m_clr) | m_rise;
        m_top = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i]) m_top = i;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev    <= 4'b0000;
            m_pend    <= 4'b0000;
            m_ovf     <= 1'b0;
            m_present <= 1'b0;
            m_code    <= 0;
        end else begin
            m_prev <= y;
            m_pend <= m_pend_n;
            if ((m_rise & m_pend & ~m_clr) != 4'b0000) m_ovf <= 1'b1;
            if (m_present) begin
                if (ack) m_present <= 1'b0;
            end else if (m_pend != 4'b0000) begin
                m_present <= 1'b1;
                m_code    <= m_top;
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare on every falling edge.
    always @(negedge clk) begin
        check("m_valid", {3'b0, valid}, {3'b0, m_present});
        check("m_pend", pend, m_pend);
        check("m_ovf", {3'b0, ovf}, {3'b0, m_ovf});
        if (m_present) check("m_code", {2'b0, a, b}, m_code[3:0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic v,
                              input logic [1:0] code,
                              input logic [3:0] p, input logic o);
        check({name, "_valid"}, {3'b0, valid}, {3'b0, v});
        if (v) check({name, "_code"}, {2'b0, a, b}, {2'b0, code});
        check({name, "_pend"}, pend, p);
        check({name, "_ovf"}, {3'b0, ovf}, {3'b0, o});
    endtask

    initial begin
        rst_n = 1'b0;
        y     = 4'b0000;
        ack   = 1'b0;
        #2;
        step();
        check("reset_ab", {2'b0, a, b}, 4'b0000);
        expect_out("reset", 1'b0, 2'b00, 4'b0000, 1'b0);
        step();
        rst_n = 1'b1;

        // 1: single request on y1
        y = 4'b0010; step(); y = 4'b0000;
        expect_out("t1_set", 1'b0, 2'b00, 4'b0010, 1'b0);
        step();
        expect_out("t1_pres", 1'b1, 2'b01, 4'b0010, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        expect_out("t1_ack", 1'b0, 2'b00, 4'b0000, 1'b0);

        // 2: y0 and y2 together, back-to-back codes
        y = 4'b0101; step(); y = 4'b0000;
        step();
        expect_out("t2_first", 1'b1, 2'b10, 4'b0101, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        expect_out("t2_gap", 1'b0, 2'b00, 4'b0001, 1'b0);
        step();
        expect_out("t2_second", 1'b1, 2'b00, 4'b0001, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        expect_out("t2_done", 1'b0, 2'b00, 4'b0000, 1'b0);

        // 3: higher priority arrival does not preempt
        y = 4'b0010; step(); y = 4'b0000;
        step();
        y = 4'b1000; step(); y = 4'b0000;
        expect_out("t3_hold", 1'b1, 2'b01, 4'b1010, 1'b0);
        step();
        expect_out("t3_hold2", 1'b1, 2'b01, 4'b1010, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        step();
        expect_out("t3_next", 1'b1, 2'b11, 4'b1000, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;

        // 4: overflow on a repeated y2, sticky across ack
        y = 4'b0100; step(); y = 4'b0000;
        step();
        y = 4'b0100; step(); y = 4'b0000;
        expect_out("t4_ovf", 1'b1, 2'b10, 4'b0100, 1'b1);
        ack = 1'b1; step(); ack = 1'b0;
        expect_out("t4_sticky", 1'b0, 2'b00, 4'b0000, 1'b1);
        step();

        // 4b: set and clear in the same cycle, from a clean ovf
        do_reset();
        y = 4'b0100; step(); y = 4'b0000;
        step();
        y = 4'b0100; ack = 1'b1; step(); y = 4'b0000; ack = 1'b0;
        expect_out("t4_setwin", 1'b0, 2'b00, 4'b0100, 1'b0);
        step();
        expect_out("t4_repres", 1'b1, 2'b10, 4'b0100, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;

        // 5: async reset during PRESENT, y0 held through release
        y = 4'b1011; step(); y = 4'b0000;
        step();
        expect_out("t5_pres", 1'b1, 2'b11, 4'b1011, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_ab", {2'b0, a, b}, 4'b0000);
        expect_out("t5_rst", 1'b0, 2'b00, 4'b0000, 1'b0);
        y = 4'b0001;
        step();
        rst_n = 1'b1;
        step();
        expect_out("t5_cap", 1'b0, 2'b00, 4'b0001, 1'b0);
        step();
        expect_out("t5_pres2", 1'b1, 2'b00, 4'b0001, 1'b0);
        y = 4'b0000;
        ack = 1'b1; step(); ack = 1'b0;
        expect_out("t5_done", 1'b0, 2'b00, 4'b0000, 1'b0);

        // Random traffic, checked by the model only
        for (int i = 0; i < 300; i++) begin
            y   = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            ack = 1'($urandom_range(0, 1));
            step();
        end
        y   = 4'b0000;
        ack = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
